// File: rtl/nd_2to1_pkg.sv
// Shared definitions for the nd_2to1 merge node: channel widths, on/off levels,
// output FSM state encoding and the two-phase pending test.
package nd_2to1_pkg;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 8;

    localparam logic NS_ON  = 1'b1;
    localparam logic NS_OFF = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } nd_state_t;

    // A two-phase channel carries a message whenever the toggles disagree.
    function automatic logic pending(input logic req, input logic ack);
        return req != ack;
    endfunction

endpackage

// File: rtl/nd_2to1_if.sv
// Two-phase message channel: req/ack toggles plus address and data fields.
// The sender owns req/addr/dat, the receiver owns ack.
interface nd_2to1_if
    import nd_2to1_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE
) ();

    logic           req;
    logic           ack;
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] dat;

    modport master (output req, output addr, output dat, input ack);
    modport slave  (input req, input addr, input dat, output ack);

endinterface

// File: rtl/nd_rcv_buf.sv
// One-slot capture buffer for a single input channel of nd_2to1.
// Captures a pending message only while empty and acknowledges it by toggling ack.
module nd_rcv_buf
    import nd_2to1_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE
) (
    input  logic           clk,
    input  logic           rst,
    nd_2to1_if.slave       rcv,
    input  logic           clr,
    output logic           full,
    output logic [ASZ-1:0] addr,
    output logic [DSZ-1:0] dat
);

    logic ack_q;
    logic cap;

    // Gating on !full means the edge that frees the slot cannot also refill it.
    assign cap     = pending(rcv.req, ack_q) && !full;
    assign rcv.ack = ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            full  <= 1'b0;
            addr  <= '0;
            dat   <= '0;
        end else if (cap) begin
            addr  <= rcv.addr;
            dat   <= rcv.dat;
            full  <= 1'b1;
            ack_q <= ~ack_q;
        end else if (clr) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/nd_2to1.sv
// Two-input merge node: two buffered two-phase inputs arbitrated onto one output.
// Define NS_ND_2TO1_FIXED_PRIO_EN for fixed priority (rcv0 wins); default is round-robin.
module nd_2to1
    import nd_2to1_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE
) (
    input  logic       i_clk,
    input  logic       reset,
    output logic       ready,
    nd_2to1_if.slave   rcv0,
    nd_2to1_if.slave   rcv1,
    nd_2to1_if.master  snd0
);

    logic           full0, full1;
    logic [ASZ-1:0] baddr0, baddr1;
    logic [DSZ-1:0] bdat0, bdat1;

    nd_state_t      state_q, state_d;
    logic           take;
    logic           sel;
    logic           prio_sel;

    logic           req_q;
    logic [ASZ-1:0] addr_q;
    logic [DSZ-1:0] dat_q;

    nd_rcv_buf #(.ASZ(ASZ), .DSZ(DSZ)) u_buf0 (
        .clk  (i_clk),
        .rst  (reset),
        .rcv  (rcv0),
        .clr  (take && !sel),
        .full (full0),
        .addr (baddr0),
        .dat  (bdat0)
    );

    nd_rcv_buf #(.ASZ(ASZ), .DSZ(DSZ)) u_buf1 (
        .clk  (i_clk),
        .rst  (reset),
        .rcv  (rcv1),
        .clr  (take && sel),
        .full (full1),
        .addr (baddr1),
        .dat  (bdat1)
    );

`ifdef NS_ND_2TO1_FIXED_PRIO_EN
    assign prio_sel = 1'b0;
`else
    logic ptr_q;

    // The pointer names the input that wins the next tie: always the one not just served.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (take) begin
            ptr_q <= ~sel;
        end
    end

    assign prio_sel = ptr_q;
`endif

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        sel     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full0 || full1) begin
                    take    = 1'b1;
                    state_d = ST_SEND;
                    sel     = (full0 && full1) ? prio_sel : full1;
                end
            end
            ST_SEND: begin
                if (!pending(req_q, snd0.ack)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready   <= NS_OFF;
            req_q   <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ready   <= NS_ON;
            if (take) begin
                req_q  <= ~req_q;
                addr_q <= sel ? baddr1 : baddr0;
                dat_q  <= sel ? bdat1 : bdat0;
            end
        end
    end

    assign snd0.req  = req_q;
    assign snd0.addr = addr_q;
    assign snd0.dat  = dat_q;

endmodule

// File: tb/tb_nd_2to1.sv
// Scoreboard bench for nd_2to1: directed vectors push expected messages,
// a monitor pops and compares each new message on snd0.
module tb_nd_2to1;
    import nd_2to1_pkg::*;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } msg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready;

    always #5 clk = ~clk;

    nd_2to1_if rcv0_if ();
    nd_2to1_if rcv1_if ();
    nd_2to1_if snd0_if ();

    nd_2to1 dut (
        .i_clk (clk),
        .reset (rst),
        .ready (ready),
        .rcv0  (rcv0_if),
        .rcv1  (rcv1_if),
        .snd0  (snd0_if)
    );

    msg_t exp_q[$];
    msg_t q0[$];
    msg_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   outs = 0;
    int   ack_dly = 0;
    logic hold = 1'b0;
    logic abort = 1'b0;
    logic rnd_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial begin : monitor
        logic last;
        msg_t m;
        msg_t e;
        bit   got;
        last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 1'b0;
            end else if (snd0_if.req != last) begin
                last = snd0_if.req;
                m.a  = snd0_if.addr;
                m.d  = snd0_if.dat;
                outs++;
                got = 1'b0;
                if (!rnd_mode) begin
                    if (exp_q.size() > 0) begin e = exp_q.pop_front(); got = 1'b1; end
                end else if (m.a[7]) begin
                    if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                end else begin
                    if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                end
                if (!got) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got addr %0h dat %0h expected none", m.a, m.d);
                end else begin
                    check("out_addr", 32'(m.a), 32'(e.a));
                    check("out_dat", 32'(m.d), 32'(e.d));
                end
            end
        end
    end

    initial begin : responder
        int cnt;
        cnt = 0;
        snd0_if.ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                snd0_if.ack = 1'b0;
                cnt = 0;
            end else if (snd0_if.req != snd0_if.ack && !hold) begin
                if (cnt >= ack_dly) begin
                    snd0_if.ack = snd0_if.req;
                    cnt = 0;
                    if (rnd_mode) ack_dly = $urandom_range(0, 7);
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic send(input int ch, input logic [7:0] a, input logic [7:0] d);
        bit done;
        done = 1'b0;
        if (abort) return;
        if (rnd_mode) begin
            if (ch == 0) q0.push_back('{a, d});
            else         q1.push_back('{a, d});
        end
        if (ch == 0) begin
            rcv0_if.addr = a; rcv0_if.dat = d; rcv0_if.req = ~rcv0_if.req;
        end else begin
            rcv1_if.addr = a; rcv1_if.dat = d; rcv1_if.req = ~rcv1_if.req;
        end
        for (int i = 0; i < 400 && !done && !abort; i++) begin
            @(negedge clk);
            done = (ch == 0) ? (rcv0_if.ack == rcv0_if.req) : (rcv1_if.ack == rcv1_if.req);
        end
        if (!abort) check("send_acked", 32'(done), 32'd1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        abort = 1'b1;
        rcv0_if.req = 1'b0; rcv0_if.addr = '0; rcv0_if.dat = '0;
        rcv1_if.req = 1'b0; rcv1_if.addr = '0; rcv1_if.dat = '0;
        exp_q.delete(); q0.delete(); q1.delete();
        repeat (n) @(negedge clk);
        rst = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        check("drain_left", 32'(exp_q.size() + q0.size() + q1.size()), 32'd0);
    endtask

    initial begin : stimulus
        int outs_start;
        rcv0_if.req = 1'b0; rcv0_if.addr = '0; rcv0_if.dat = '0;
        rcv1_if.req = 1'b0; rcv1_if.addr = '0; rcv1_if.dat = '0;

        // Reset held for three cycles, then idle with no input
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 32'(ready), 32'd0);
            check("rst_snd_req", 32'(snd0_if.req), 32'd0);
            check("rst_snd_addr", 32'(snd0_if.addr), 32'd0);
            check("rst_rcv0_ack", 32'(rcv0_if.ack), 32'd0);
            check("rst_rcv1_ack", 32'(rcv1_if.ack), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("idle_snd_req", 32'(snd0_if.req), 32'd0);
        end

        // Single message on rcv0, downstream acks one cycle late
        ack_dly = 1;
        exp_q.push_back('{8'h05, 8'h2A});
        rcv0_if.addr = 8'h05; rcv0_if.dat = 8'h2A; rcv0_if.req = 1'b1;
        @(negedge clk);
        check("t2_capture_ack", 32'(rcv0_if.ack), 32'd1);
        check("t2_snd_not_yet", 32'(snd0_if.req), 32'd0);
        @(negedge clk);
        check("t2_snd_req", 32'(snd0_if.req), 32'd1);
        check("t2_snd_addr", 32'(snd0_if.addr), 32'h05);
        check("t2_snd_dat", 32'(snd0_if.dat), 32'h2A);
        check("t2_rcv1_ack", 32'(rcv1_if.ack), 32'd0);
        repeat (4) @(negedge clk);
        wait_drain();

        // Both inputs saturated
        do_reset(2);
        ack_dly = 0;
`ifdef NS_ND_2TO1_FIXED_PRIO_EN
        exp_q.push_back('{8'h10, 8'd1});  exp_q.push_back('{8'h10, 8'd2});
        exp_q.push_back('{8'h10, 8'd3});  exp_q.push_back('{8'h90, 8'd11});
        exp_q.push_back('{8'h90, 8'd12}); exp_q.push_back('{8'h90, 8'd13});
`else
        exp_q.push_back('{8'h10, 8'd1});  exp_q.push_back('{8'h90, 8'd11});
        exp_q.push_back('{8'h10, 8'd2});  exp_q.push_back('{8'h90, 8'd12});
        exp_q.push_back('{8'h10, 8'd3});  exp_q.push_back('{8'h90, 8'd13});
`endif
        fork
            begin send(0, 8'h10, 8'd1);  send(0, 8'h10, 8'd2);  send(0, 8'h10, 8'd3);  end
            begin send(1, 8'h90, 8'd11); send(1, 8'h90, 8'd12); send(1, 8'h90, 8'd13); end
        join
        wait_drain();

        // Downstream withholds ack for 20 cycles
        do_reset(2);
        ack_dly = 0;
        hold = 1'b1;
`ifdef NS_ND_2TO1_FIXED_PRIO_EN
        exp_q.push_back('{8'h21, 8'hA1}); exp_q.push_back('{8'h23, 8'hC3});
        exp_q.push_back('{8'h24, 8'hD4}); exp_q.push_back('{8'hA2, 8'hB2});
`else
        exp_q.push_back('{8'h21, 8'hA1}); exp_q.push_back('{8'hA2, 8'hB2});
        exp_q.push_back('{8'h23, 8'hC3}); exp_q.push_back('{8'h24, 8'hD4});
`endif
        fork
            begin send(0, 8'h21, 8'hA1); send(0, 8'h23, 8'hC3); send(0, 8'h24, 8'hD4); end
            send(1, 8'hA2, 8'hB2);
            begin
                repeat (6) @(negedge clk);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check("t4_hold_req", 32'(snd0_if.req), 32'd1);
                    check("t4_hold_addr", 32'(snd0_if.addr), 32'h21);
                    check("t4_hold_dat", 32'(snd0_if.dat), 32'hA1);
                end
                check("t4_third_req", 32'(rcv0_if.req), 32'd1);
                check("t4_third_no_ack", 32'(rcv0_if.ack), 32'd0);
                check("t4_rcv1_acked", 32'(rcv1_if.ack), 32'd1);
                hold = 1'b0;
            end
        join
        wait_drain();

        // Reset while sending with both buffers full
        do_reset(2);
        ack_dly = 0;
        hold = 1'b1;
        exp_q.push_back('{8'h21, 8'hA1});
        fork
            begin send(0, 8'h21, 8'hA1); send(0, 8'h23, 8'hC3); send(0, 8'h24, 8'hD4); end
            send(1, 8'hA2, 8'hB2);
            begin
                repeat (8) @(negedge clk);
                rst = 1'b1;
                abort = 1'b1;
                rcv0_if.req = 1'b0;
                rcv1_if.req = 1'b0;
                exp_q.delete();
                @(negedge clk);
                check("t5_ready", 32'(ready), 32'd0);
                check("t5_snd_req", 32'(snd0_if.req), 32'd0);
                check("t5_snd_addr", 32'(snd0_if.addr), 32'd0);
                check("t5_snd_dat", 32'(snd0_if.dat), 32'd0);
                check("t5_rcv0_ack", 32'(rcv0_if.ack), 32'd0);
                check("t5_rcv1_ack", 32'(rcv1_if.ack), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                abort = 1'b0;
                hold = 1'b0;
            end
        join
        repeat (3) begin
            @(negedge clk);
            check("t5_no_stale", 32'(snd0_if.req), 32'd0);
        end
        exp_q.push_back('{8'd55, 8'h5A});
        send(0, 8'd55, 8'h5A);
        wait_drain();

        // Random traffic with random downstream ack delay
        do_reset(2);
        rnd_mode = 1'b1;
        ack_dly = 0;
        outs_start = outs;
        fork
            for (int i = 0; i < 300; i++) begin
                send(0, {1'b0, 7'(i)}, 8'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            for (int j = 0; j < 300; j++) begin
                send(1, {1'b1, 7'(j)}, 8'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        join
        wait_drain();
        check("t6_out_count", 32'(outs - outs_start), 32'd600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
